instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming instruction encoder: the inverse of the core's instruction decode stage.
- Accepts symbolic micro-op requests (class + register/immediate fields) over a valid/ready handshake.
- Packs each request into the 32-bit word format the multi-cycle core decodes, including custom MUL/long-MUL/float/MOVT/MOVM encodings.
- Buffers encoded words in a FIFO and presents each with a byte address, for program loaders and the self-test stimulus generator.

Parameters:
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- BASE_ADDR, 32'h0: byte address attached to the first word after reset or clear.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; empties FIFO and reloads address counter to BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_class  in  5  op class (see Behaviour).
- in_cond  in  4  condition field.
- in_s  in  1  set-flags bit.
- in_imm_sel  in  1  immediate form for classes 0-4.
- in_rd, in_rn, in_rm, in_ra  in  4 each  register fields.
- in_imm  in  24  imm12 in [11:0]; imm24 for B.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- out_instr  out  32  encoded word at head.
- out_addr  out  32  byte address of head word.
- err  out  1  one-cycle pulse on an accepted illegal class.
- err_count  out  8  illegal-request counter (optional feature).

Behaviour:
- Reset: FIFO empty; out_valid=0; out_instr=0; out_addr=0; err=0; err_count=0; address counter=BASE_ADDR.
- in_ready = (count < DEPTH) & ~clear. There is no combinational path from out_ready, so a pop in the full cycle does not raise in_ready.
- Latency: request accepted in cycle N → word at the head with out_valid=1 in cycle N+1 if the FIFO was empty. Otherwise the word is queued in order.
- Simultaneous push and pop: count is unchanged and both take effect.
- Each legal push stores {word, addr}. The address counter then increments by 4 and wraps modulo 2^32.
- Illegal class (20-31) on acceptance: no push, address unchanged, err=1 for exactly one cycle.
- clear has priority over push/pop in the same cycle. Any request presented that cycle is dropped and in_ready=0.
- out_instr and out_addr are held stable while out_valid & ~out_ready.
- Common word layout: [31:28]=in_cond. For data-processing words, [19:16]=rn and [15:12]=rd. Register forms put rm in [3:0] with [11:4]=0. Immediate forms put imm[11:0] in [11:0].
- Data-processing classes, [27:26]=00, opcode in [24:21]:
  - 0 ADD 0100; 1 SUB 0010; 2 AND 0000; 3 ORR 1100; 4 DIV 0001. I=[25]=in_imm_sel, S=in_s.
  - 5 CMP: I=0, op 1111, S forced 1, rd field 0.
  - 6 MOV_REG: I=0, op 1101, rn field 0.
  - 7 MOV_IMM: I=1, op 1101, rn field 0.
  - 8 MOVT: I=1, op 1010, rn field 0.
  - 9 MOVM: I=1, op 1110, rn field 0.
- Multiplies:
  - 10 MUL: [27:20]={7'b0,S}, [19:16]=rd, [15:12]=0, [11:8]=rm, [7:4]=1001, [3:0]=rn.
  - 11 UMULL / 12 SMULL: [27:23]=00001, [22]=signed, [21]=0, [20]=S, [19:16]=ra (RdHi), [15:12]=rd (RdLo), [11:8]=rm, [7:4]=1001, [3:0]=rn.
- Floats:
  - 13 FADDS / 14 FMULS: op 1000, I=0.
  - 15 FADDH / 16 FMULH: op 1001, I=0.
  - For all four: [11:5]=0, [4]=1 for multiply, [3:0]=rm.
- Memory, 17 LDR / 18 STR: [27:20]=0101_100L with L=1 for LDR, [19:16]=rn, [15:12]=rd, [11:0]=imm[11:0].
- Branch, 19 B: [27:24]=1010, [23:0]=in_imm.
- Encoding is combinational from the request fields and registered at FIFO write.

Optional Feature:
- INSTR_ENC_ERRCNT_EN defined: err_count increments on each err pulse, saturates at 255, and is cleared by reset or clear.
- INSTR_ENC_ERRCNT_EN undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
- ADD class 0, cond E, rd=1, rn=2, rm=3, S=0, imm_sel=0 → next cycle out_valid=1, out_instr=0xE0821003, out_addr=BASE_ADDR.
- SUB class 1, imm_sel=1, S=1, rd=4, rn=5, imm=0x10, then UMULL rd=0, ra=1, rn=2, rm=3, then SMULL with the same fields, all with out_ready=1 → words 0xE2554010, 0xE0810392, 0xE0C10392 at addresses +0, +4, +8.
- LDR rd=0, rn=1, imm=8, then B imm=0x000010 → 0xE5910008 then 0xEA000010.
- Class 25 request → err high for exactly one cycle, no word pushed, next legal word takes the unchanged address. With INSTR_ENC_ERRCNT_EN, err_count=1.
- DEPTH=2, out_ready=0, push 3 requests → in_ready=0 after 2 pushes. Then pulse out_ready for 1 cycle → one pop, in_ready=1 the following cycle, order preserved.
- Assert clear with 2 words queued, and separately drop reset mid-stream → out_valid=0 next cycle, next word's address is BASE_ADDR. Reset acts without a clock edge.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
// The encoder is the slave: it takes symbolic requests and presents encoded words.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_class;
  logic [3:0]  in_cond;
  logic        in_s;
  logic        in_imm_sel;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [3:0]  in_rm;
  logic [3:0]  in_ra;
  logic [23:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_class, in_cond, in_s, in_imm_sel, in_rd, in_rn, in_rm, in_ra, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport slave (
    input  in_valid, in_class, in_cond, in_s, in_imm_sel, in_rd, in_rn, in_rm, in_ra, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs symbolic micro-op requests into the core's 32-bit
// word format and queues {word, byte address} in a small FIFO.
// Optional feature: define INSTR_ENC_ERRCNT_EN to build the saturating illegal-request
// counter on err_count; otherwise err_count is tied to zero.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  instr_encoder_if.slave   bus
);

  localparam int unsigned   PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  // Data-processing word: cond | 00 | I | opcode | S | rn | rd | operand2.
  function automatic logic [31:0] dp(input logic [3:0] cond, input logic i,
                                     input logic [3:0] op, input logic s,
                                     input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  logic [31:0]     enc_word;
  logic            legal;
  logic [11:0]     reg12;
  logic [11:0]     imm12;
  logic [11:0]     op2_sel;
  logic [3:0]      c;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     addr_q, addr_d;
  logic            err_q, err_d;
  logic [31:0]     word_mem [DEPTH];
  logic [31:0]     addr_mem [DEPTH];

  logic in_ready, out_valid, accept, push, pop;

  assign c       = bus.in_cond;
  assign reg12   = {8'h00, bus.in_rm};
  assign imm12   = bus.in_imm[11:0];
  assign op2_sel = bus.in_imm_sel ? imm12 : reg12;

  // Combinational encode of the current request; classes 20-31 flag illegal.
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (bus.in_class)
      5'd0:  enc_word = dp(c, bus.in_imm_sel, 4'b0100, bus.in_s, bus.in_rn, bus.in_rd, op2_sel);
      5'd1:  enc_word = dp(c, bus.in_imm_sel, 4'b0010, bus.in_s, bus.in_rn, bus.in_rd, op2_sel);
      5'd2:  enc_word = dp(c, bus.in_imm_sel, 4'b0000, bus.in_s, bus.in_rn, bus.in_rd, op2_sel);
      5'd3:  enc_word = dp(c, bus.in_imm_sel, 4'b1100, bus.in_s, bus.in_rn, bus.in_rd, op2_sel);
      5'd4:  enc_word = dp(c, bus.in_imm_sel, 4'b0001, bus.in_s, bus.in_rn, bus.in_rd, op2_sel);
      5'd5:  enc_word = dp(c, 1'b0, 4'b1111, 1'b1, bus.in_rn, 4'h0, reg12);
      5'd6:  enc_word = dp(c, 1'b0, 4'b1101, bus.in_s, 4'h0, bus.in_rd, reg12);
      5'd7:  enc_word = dp(c, 1'b1, 4'b1101, bus.in_s, 4'h0, bus.in_rd, imm12);
      5'd8:  enc_word = dp(c, 1'b1, 4'b1010, bus.in_s, 4'h0, bus.in_rd, imm12);
      5'd9:  enc_word = dp(c, 1'b1, 4'b1110, bus.in_s, 4'h0, bus.in_rd, imm12);
      5'd10: enc_word = {c, 7'b0, bus.in_s, bus.in_rd, 4'h0, bus.in_rm, 4'b1001, bus.in_rn};
      5'd11: enc_word = {c, 5'b00001, 1'b0, 1'b0, bus.in_s, bus.in_ra, bus.in_rd, bus.in_rm,
                         4'b1001, bus.in_rn};
      5'd12: enc_word = {c, 5'b00001, 1'b1, 1'b0, bus.in_s, bus.in_ra, bus.in_rd, bus.in_rm,
                         4'b1001, bus.in_rn};
      5'd13: enc_word = dp(c, 1'b0, 4'b1000, bus.in_s, bus.in_rn, bus.in_rd,
                           {8'h00, bus.in_rm});
      5'd14: enc_word = dp(c, 1'b0, 4'b1000, bus.in_s, bus.in_rn, bus.in_rd,
                           {7'h00, 1'b1, bus.in_rm});
      5'd15: enc_word = dp(c, 1'b0, 4'b1001, bus.in_s, bus.in_rn, bus.in_rd,
                           {8'h00, bus.in_rm});
      5'd16: enc_word = dp(c, 1'b0, 4'b1001, bus.in_s, bus.in_rn, bus.in_rd,
                           {7'h00, 1'b1, bus.in_rm});
      5'd17: enc_word = {c, 8'b0101_1001, bus.in_rn, bus.in_rd, imm12};
      5'd18: enc_word = {c, 8'b0101_1000, bus.in_rn, bus.in_rd, imm12};
      5'd19: enc_word = {c, 4'b1010, bus.in_imm};
      default: legal = 1'b0;
    endcase
  end

  // Ready depends only on local state and clear, never on out_ready.
  assign in_ready  = (count_q != CntFull) & ~clear;
  assign out_valid = (count_q != '0);
  assign accept    = bus.in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & bus.out_ready & ~clear;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? word_mem[rd_ptr_q] : '0;
  assign bus.out_addr  = out_valid ? addr_mem[rd_ptr_q] : '0;
  assign bus.err       = err_q;

  // Next-state for pointers, occupancy, address counter and error pulse; clear wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = accept & ~legal;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        addr_d   = addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are only visible through out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q] <= addr_q;
    end
  end

`ifdef INSTR_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of illegal requests, advanced alongside the err pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (clear) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic against a
// queue-based reference model with an arithmetic encoder.
module tb_instr_encoder;
  localparam int unsigned Depth    = 2;
  localparam logic [31:0] BaseAddr = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(Depth), .BASE_ADDR(BaseAddr)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] q[$];
  logic [31:0] next_addr;
  int          exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_enc(input int unsigned cls, input int unsigned cond,
                                          input int unsigned s, input int unsigned isel,
                                          input int unsigned rd, input int unsigned rn,
                                          input int unsigned rm, input int unsigned ra,
                                          input int unsigned imm);
    int unsigned w, i, sf, op, sg, mul;
    int unsigned dp_op[10] = '{4, 2, 0, 12, 1, 15, 13, 13, 10, 14};
    w = cond << 28;
    if (cls < 10) begin
      i  = (cls < 5) ? isel : ((cls >= 7) ? 1 : 0);
      sf = (cls == 5) ? 1 : s;
      w += (i << 25) + (dp_op[cls] << 21) + (sf << 20);
      if (cls < 6) w += rn << 16;
      if (cls != 5) w += rd << 12;
      w += (i != 0) ? (imm % 4096) : rm;
    end else if (cls == 10) begin
      w += (s << 20) + (rd << 16) + (rm << 8) + (9 << 4) + rn;
    end else if (cls <= 12) begin
      sg = (cls == 12) ? 1 : 0;
      w += (1 << 23) + (sg << 22) + (s << 20) + (ra << 16) + (rd << 12) + (rm << 8)
           + (9 << 4) + rn;
    end else if (cls <= 16) begin
      op  = (cls < 15) ? 8 : 9;
      mul = (cls == 14 || cls == 16) ? 1 : 0;
      w += (op << 21) + (s << 20) + (rn << 16) + (rd << 12) + (mul << 4) + rm;
    end else if (cls <= 18) begin
      op = (cls == 17) ? 89 : 88;
      w += (op << 20) + (rn << 16) + (rd << 12) + (imm % 4096);
    end else begin
      w += (10 << 24) + (imm % 16777216);
    end
    return w;
  endfunction

  task automatic req(input int unsigned cls, input int unsigned cond, input int unsigned s,
                     input int unsigned isel, input int unsigned rd, input int unsigned rn,
                     input int unsigned rm, input int unsigned ra, input int unsigned imm);
    bus.in_valid   = 1'b1;
    bus.in_class   = 5'(cls);
    bus.in_cond    = 4'(cond);
    bus.in_s       = 1'(s);
    bus.in_imm_sel = 1'(isel);
    bus.in_rd      = 4'(rd);
    bus.in_rn      = 4'(rn);
    bus.in_rm      = 4'(rm);
    bus.in_ra      = 4'(ra);
    bus.in_imm     = 24'(imm);
  endtask

  task automatic rand_req();
    req($urandom_range(0, 23), $urandom_range(0, 15), $urandom_range(0, 1),
        $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
        $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 24'hFF_FFFF));
    bus.in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    q.delete();
    next_addr = BaseAddr;
    exp_cnt   = 0;
  endtask

  // One clock: check pre-edge outputs, advance the model, check the error outputs.
  task automatic cycle();
    bit          exp_ready, acc, pop, exp_err;
    logic [31:0] w;
    logic [63:0] head;
    #1;
    exp_ready = (q.size() < Depth) && !clear;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    head = (q.size() > 0) ? q[0] : 64'h0;
    check("out_instr", bus.out_instr, head[31:0]);
    check("out_addr", bus.out_addr, head[63:32]);
    acc = bus.in_valid && exp_ready;
    pop = (q.size() > 0) && bus.out_ready && !clear;
    w   = ref_enc(bus.in_class, bus.in_cond, bus.in_s, bus.in_imm_sel, bus.in_rd, bus.in_rn,
                  bus.in_rm, bus.in_ra, bus.in_imm);
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && bus.in_class < 20) begin
        q.push_back({next_addr, w});
        next_addr += 32'd4;
      end
      exp_err = acc && (bus.in_class >= 20);
`ifdef INSTR_ENC_ERRCNT_EN
      if (exp_err && exp_cnt < 255) exp_cnt++;
`endif
    end
    check("err", 32'(bus.err), 32'(exp_err));
    check("err_count", 32'(bus.err_count), 32'(exp_cnt));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_addr", bus.out_addr, 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_err_count", 32'(bus.err_count), 32'h0);
    model_reset();
    #11 reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodings with the consumer always ready.
    bus.out_ready = 1'b1;
    req(0, 14, 0, 0, 1, 2, 3, 0, 0);
    cycle();
    check("add_word", bus.out_instr, 32'hE082_1003);
    check("add_addr", bus.out_addr, BaseAddr);
    req(1, 14, 1, 1, 4, 5, 0, 0, 24'h10);
    cycle();
    check("sub_word", bus.out_instr, 32'hE255_4010);
    req(11, 14, 0, 0, 0, 2, 3, 1, 0);
    cycle();
    check("umull_word", bus.out_instr, 32'hE081_0392);
    check("umull_addr_wrap", bus.out_addr, 32'h0000_0000);
    req(12, 14, 0, 0, 0, 2, 3, 1, 0);
    cycle();
    check("smull_word", bus.out_instr, 32'hE0C1_0392);
    req(17, 14, 0, 0, 0, 1, 0, 0, 8);
    cycle();
    check("ldr_word", bus.out_instr, 32'hE591_0008);
    req(19, 14, 0, 0, 0, 0, 0, 0, 24'h10);
    cycle();
    check("b_word", bus.out_instr, 32'hEA00_0010);
    idle();
    cycle();

    // Illegal class: one-cycle err, no push, address unchanged.
    req(25, 14, 0, 0, 1, 2, 3, 0, 0);
    cycle();
    check("illegal_err", 32'(bus.err), 32'h1);
    idle();
    cycle();
    req(6, 14, 0, 0, 7, 0, 9, 0, 0);
    cycle();
    check("after_illegal_addr", bus.out_addr, BaseAddr + 32'd24);
    idle();
    cycle();
    cycle();

    // Fill to full with the consumer stalled, then a single-cycle pop.
    bus.out_ready = 1'b0;
    req(2, 1, 1, 0, 3, 4, 5, 0, 0);
    cycle();
    req(3, 2, 0, 1, 6, 7, 0, 0, 12'hABC);
    cycle();
    req(4, 3, 1, 1, 8, 9, 0, 0, 12'h123);
    cycle();
    check("full_no_ready", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    idle();
    cycle();

    // Synchronous clear with two words queued; a request in that cycle is dropped.
    clear = 1'b1;
    req(13, 4, 0, 0, 1, 1, 1, 0, 0);
    cycle();
    clear = 1'b0;
    idle();
    cycle();
    req(14, 5, 1, 0, 2, 3, 4, 0, 0);
    cycle();
    check("clear_base_addr", bus.out_addr, BaseAddr);
    idle();
    bus.out_ready = 1'b1;
    cycle();

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      rand_req();
      bus.out_ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clear = 1'b0;

    // Asynchronous reset mid-stream, between clock edges.
    bus.out_ready = 1'b0;
    req(15, 6, 0, 0, 1, 2, 3, 0, 0);
    cycle();
    req(16, 7, 1, 0, 4, 5, 6, 0, 0);
    cycle();
    idle();
    #2 reset = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_out_addr", bus.out_addr, 32'h0);
    check("async_rst_err_count", 32'(bus.err_count), 32'h0);
    model_reset();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    req(18, 8, 0, 0, 3, 4, 0, 0, 12'h7FF);
    cycle();
    check("rst_base_addr", bus.out_addr, BaseAddr);
    for (int k = 0; k < 100; k++) begin
      rand_req();
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
